mdu_seq: RTL
============

// Module: mdu_seq
// PURPOSE
//  Multi-cycle RV32M multiply/divide unit beside the single-cycle ALU in EX.
//  Takes operands and an M-extension funct3 via valid/ready, iterates 1 bit/cycle
//  (shift-add multiply, restoring divide), returns one 32-bit result via valid/ready.
//  Pipeline stalls EX while start_ready=0 or result pending; flush kills the op.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk           in   1     rising-edge clock
//  rst_n         in   1     asynchronous reset, active low
//  start_valid   in   1     operation request valid
//  start_ready   out  1     unit can accept (high only in IDLE)
//  op            in   3     funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  Arg1          in   XLEN  rs1 operand
//  Arg2          in   XLEN  rs2 operand
//  flush         in   1     abort current op (branch/trap)
//  result_valid  out  1     MDUResult valid, held until accepted
//  result_ready  in   1     consumer takes result
//  MDUResult     out  XLEN  result, registered
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, start_ready=1, result_valid=0, MDUResult=0, counter=0.
//  States: IDLE -> CALC -> DONE -> IDLE.
//  IDLE: start_ready=1. start_valid=1 on edge: latch op, |Arg1|,|Arg2| per signedness,
//   latch result sign; go CALC, counter=0. Exception: DIV/DIVU/REM/REMU with Arg2=0
//   or DIV/REM with Arg1=0x80000000,Arg2=0xFFFFFFFF -> skip CALC, go DONE directly.
//  Signedness: MUL/MULH/DIV/REM both signed; MULHSU Arg1 signed, Arg2 unsigned;
//   MULHU/DIVU/REMU unsigned. Magnitude of 0x80000000 is 2^31 (33-bit internal math).
//  CALC: one iteration per cycle, counter 0..XLEN-1; on counter=XLEN-1 go DONE.
//   Multiply: 64-bit unsigned product accumulator, shift-add LSB-first.
//   Divide: restoring, MSB-first; 32-bit quotient, 32-bit remainder.
//  DONE entry: MDUResult registered, result_valid=1.
//   MUL = low 32 of signed product; MULH/MULHSU/MULHU = high 32 of sign-corrected 64-bit product.
//   DIV/DIVU = quotient, REM/REMU = remainder; quotient negated if operand signs differ (signed ops),
//   remainder takes sign of Arg1 (signed ops).
//   Div-by-zero: quotient=0xFFFFFFFF (all ops), remainder=Arg1.
//   Signed overflow: quotient=0x80000000, remainder=0.
//  Latency: accept edge -> result_valid high 33 cycles later (normal); 1 cycle (exception cases).
//  DONE: result_valid and MDUResult stable until result_valid&result_ready edge -> IDLE,
//   result_valid=0 (MDUResult holds last value). start_ready=0 in DONE; a new op is
//   accepted no earlier than the cycle after the result handshake.
//  flush=1: on next edge state=IDLE, result_valid=0, in-flight op discarded; overrides
//   start_valid and result handshake in the same cycle. flush in IDLE: start not accepted.
//  Reset mid-operation: immediate return to reset values, no result emitted.
//  Inputs Arg1/Arg2/op ignored outside the accept edge.
// TESTING
//  MUL 7 x -3 (0x00000007,0xFFFFFFFD) -> result_valid after 33 cycles, MDUResult=0xFFFFFFEB.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//  DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000; each valid 1 cycle after accept.
//  result_ready held low 10 cycles in DONE -> MDUResult/result_valid stable; start_valid ignored meanwhile.
//  flush at CALC cycle 12, and rst_n pulse mid-CALC -> IDLE next edge/immediately, no result_valid, next op correct.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M multiply/divide unit.
// Operands are converted to magnitudes on accept, iterated one bit per cycle
// (shift-add multiply LSB-first, restoring divide MSB-first), then sign-corrected
// into a registered result on the first DONE cycle.
//
// state | meaning
// IDLE  | start_ready=1, waiting for start_valid
// CALC  | one iteration per cycle, counter 0..XLEN-1
// DONE  | first cycle registers MDUResult; then result_valid held until accepted
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] Arg1,
  input  logic [XLEN-1:0] Arg2,
  input  logic            flush,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] MDUResult
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              r_state;
  logic [2:0]          r_op;
  logic [CW-1:0]       r_cnt;
  // Multiply: hi = partial product, lo = remaining multiplier bits.
  // Divide:   hi = partial remainder, lo = dividend shifting into quotient.
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_b;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_exc;
  logic                r_start_ready;
  logic                r_result_valid;
  logic [XLEN-1:0]     r_result;

  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [XLEN:0]       w_div_shift;
  logic [XLEN-1:0]     w_div_diff;
  logic                w_div_ge;
  logic [2*XLEN-1:0]   w_div_next;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_final;

  assign start_ready  = r_start_ready;
  assign result_valid = r_result_valid;
  assign MDUResult    = r_result;

  // Operand decode at the accept point: signedness, magnitudes, special divide cases.
  always_comb begin
    w_a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    w_b_signed = op[2] ? ~op[0] : ~op[1];
    w_a_neg    = w_a_signed & Arg1[XLEN-1];
    w_b_neg    = w_b_signed & Arg2[XLEN-1];
    w_a_mag    = w_a_neg ? (~Arg1 + 1'b1) : Arg1;
    w_b_mag    = w_b_neg ? (~Arg2 + 1'b1) : Arg2;
    w_div_zero = op[2] & (Arg2 == '0);
    w_div_ovf  = op[2] & ~op[0] & (Arg1 == SMIN) & (Arg2 == '1);
  end

  // One iteration of each algorithm plus the final sign correction.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
    w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_b});
    w_div_diff  = w_div_shift[XLEN-1:0] - r_b;
    w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0]),
                   r_acc[XLEN-2:0], w_div_ge};
    w_prod      = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_quo       = (r_neg_q & ~r_exc) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    w_rem       = (r_neg_r & ~r_exc) ? (~r_acc[2*XLEN-1:XLEN] + 1'b1)
                                     : r_acc[2*XLEN-1:XLEN];
    w_final     = '0;
    case (r_op)
      OP_MUL:                     w_final = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            w_final = w_quo;
      default:                    w_final = w_rem;
    endcase
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_op           <= OP_MUL;
      r_cnt          <= '0;
      r_acc          <= '0;
      r_b            <= '0;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
      r_exc          <= 1'b0;
      r_start_ready  <= 1'b1;
      r_result_valid <= 1'b0;
      r_result       <= '0;
    end else if (flush) begin
      r_state        <= S_IDLE;
      r_start_ready  <= 1'b1;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_op          <= op;
            r_cnt         <= '0;
            r_neg_q       <= w_a_neg ^ w_b_neg;
            r_neg_r       <= w_a_neg;
            r_start_ready <= 1'b0;
            if (w_div_zero) begin
              r_acc   <= {Arg1, {XLEN{1'b1}}};
              r_exc   <= 1'b1;
              r_state <= S_DONE;
            end else if (w_div_ovf) begin
              r_acc   <= {{XLEN{1'b0}}, SMIN};
              r_exc   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // Multiply keeps the multiplier in lo; divide keeps the dividend in lo.
              r_acc   <= {{XLEN{1'b0}}, (op[2] ? w_a_mag : w_b_mag)};
              r_b     <= op[2] ? w_b_mag : w_a_mag;
              r_exc   <= 1'b0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN-1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!r_result_valid) begin
            r_result       <= w_final;
            r_result_valid <= 1'b1;
          end else if (result_ready) begin
            r_result_valid <= 1'b0;
            r_start_ready  <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_start_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
